// File: rtl/sobel_pkg.sv
// sobel_pkg: shared FSM encoding and default geometry constants for the Sobel window controller.
package sobel_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_DE, ACTIVE, HBLANK} state_e;
    localparam int CNT_W_DEF = 12;
    localparam int WIDTH_DEF = 2100;
    localparam int STAT_W    = 16;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: registers one strobe and flags its rising/falling edge against the registered copy.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_o <= 1'b0;
        else      q_o <= d_i;
    end
    assign rise_o = d_i & ~q_o;
    assign fall_o = ~d_i & q_o;
endmodule

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: centre-pixel position, border/valid flags and line/frame geometry for the Sobel core.
// Defining SOBEL_WIN_STATS_EN adds the frame_cnt and ovf_cnt statistics outputs.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync_dl,
    input  logic             vsync_dl,
    input  logic             de_dl,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             win_valid,
    output logic             border,
    output logic             frame_start,
    output logic [CNT_W-1:0] line_width,
    output logic [CNT_W-1:0] frame_height,
    output logic             geom_valid,
    output logic             overflow
`ifdef SOBEL_WIN_STATS_EN
    ,
    output logic [STAT_W-1:0] frame_cnt,
    output logic [STAT_W-1:0] ovf_cnt
`endif
);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WIDTH);

    state_e           state_q, state_d;
    logic             hs_rise, hs_fall, v_rise, v_fall, de_rise, de_fall, unused;
    logic [CNT_W-1:0] col_q, col_d, row_q, row_d, lw_q, lw_d, fh_q, fh_d, col_inc, row_inc;
    logic             geom_q, geom_d, ovf_q, ovf_d, border_q, border_d, win_q, win_d, fs_q, fs_d;
    logic             pix, line_end, fh_upd, ovf_set, at_edge;

    sync_edge_det u_hs (.clk(clk), .rst(rst), .d_i(hsync_dl), .q_o(hsync_o), .rise_o(hs_rise), .fall_o(hs_fall));
    sync_edge_det u_vs (.clk(clk), .rst(rst), .d_i(vsync_dl), .q_o(vsync_o), .rise_o(v_rise),  .fall_o(v_fall));
    sync_edge_det u_de (.clk(clk), .rst(rst), .d_i(de_dl),    .q_o(de_o),    .rise_o(de_rise), .fall_o(de_fall));
    assign unused = ^{hs_rise, hs_fall, v_fall, de_rise};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // vsync rise wins over every other transition, including a mid-line one
    always_comb begin
        state_d = v_rise                               ? WAIT_DE
                : (state_q == ACTIVE)                  ? (de_fall ? HBLANK : ACTIVE)
                : (state_q != IDLE && de_dl == 1'b1)   ? ACTIVE
                :                                        state_q;
    end

    always_comb begin
        pix      = de_dl & ~v_rise & (state_q != IDLE);
        line_end = de_fall & (state_q == ACTIVE);
        fh_upd   = v_rise & (state_q == ACTIVE || state_q == HBLANK);
        col_inc  = &col_q ? col_q : col_q + ONE;
        row_inc  = &row_q ? row_q : row_q + ONE;
        col_d    = pix ? ((state_q == ACTIVE) ? col_inc : '0) : col_q;
        row_d    = v_rise ? '0 : line_end ? row_inc : row_q;
        lw_d     = line_end ? col_inc : lw_q;
        fh_d     = fh_upd ? (line_end ? row_inc : row_q) : fh_q;
        geom_d   = geom_q | fh_upd;
        ovf_set  = pix & (col_d >= LIMIT);
        ovf_d    = ~v_rise & (ovf_q | ovf_set);
        // right/bottom edges only become known once a full frame has been measured
        at_edge  = col_d == '0 || row_d == '0 || (geom_q && (col_d == lw_q - ONE || row_d == fh_q - ONE));
        border_d = pix & at_edge;
        win_d    = pix & ~at_edge;
        fs_d     = pix & (state_q == WAIT_DE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q    <= '0;
            row_q    <= '0;
            lw_q     <= '1;
            fh_q     <= '1;
            geom_q   <= 1'b0;
            ovf_q    <= 1'b0;
            border_q <= 1'b0;
            win_q    <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            lw_q     <= lw_d;
            fh_q     <= fh_d;
            geom_q   <= geom_d;
            ovf_q    <= ovf_d;
            border_q <= border_d;
            win_q    <= win_d;
            fs_q     <= fs_d;
        end
    end

    assign col          = col_q;
    assign row          = row_q;
    assign line_width   = lw_q;
    assign frame_height = fh_q;
    assign geom_valid   = geom_q;
    assign overflow     = ovf_q;
    assign border       = border_q;
    assign win_valid    = win_q;
    assign frame_start  = fs_q;

`ifdef SOBEL_WIN_STATS_EN
    logic [STAT_W-1:0] frame_cnt_q, ovf_cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            if (fs_d) frame_cnt_q <= frame_cnt_q + STAT_W'(1);
            if (v_rise && ovf_q && !(&ovf_cnt_q)) ovf_cnt_q <= ovf_cnt_q + STAT_W'(1);
        end
    end
    assign frame_cnt = frame_cnt_q;
    assign ovf_cnt   = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl: frame-level reference model driving directed and random frames into sobel_window_ctrl.
module tb_sobel_window_ctrl;
    localparam int W = 8;

    logic        clk = 1'b0, rst = 1'b0, hsync_dl = 1'b0, vsync_dl = 1'b0, de_dl = 1'b0;
    logic        hsync_o, vsync_o, de_o, win_valid, border, frame_start, geom_valid, overflow;
    logic [11:0] col, row, line_width, frame_height;
`ifdef SOBEL_WIN_STATS_EN
    logic [15:0] frame_cnt, ovf_cnt;
`endif

    int checks = 0, errors = 0, wv_cnt = 0;
    int lw, fh, lines, fcnt, ocnt;
    bit geom, ovf, active, in_frame;

    sobel_window_ctrl #(.WIDTH(W), .CNT_W(12)) dut (
        .clk(clk), .rst(rst), .hsync_dl(hsync_dl), .vsync_dl(vsync_dl), .de_dl(de_dl),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .col(col), .row(row),
        .win_valid(win_valid), .border(border), .frame_start(frame_start),
        .line_width(line_width), .frame_height(frame_height), .geom_valid(geom_valid), .overflow(overflow)
`ifdef SOBEL_WIN_STATS_EN
        , .frame_cnt(frame_cnt), .ovf_cnt(ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        geom = 0; lw = 4095; fh = 4095; ovf = 0; active = 0; in_frame = 0; lines = 0; fcnt = 0; ocnt = 0;
    endtask

    task automatic chk_reset();
        chk("rst_hsync_o", hsync_o, 0);   chk("rst_vsync_o", vsync_o, 0);     chk("rst_de_o", de_o, 0);
        chk("rst_col", col, 0);           chk("rst_row", row, 0);             chk("rst_win_valid", win_valid, 0);
        chk("rst_border", border, 0);     chk("rst_frame_start", frame_start, 0);
        chk("rst_line_width", line_width, 4095); chk("rst_frame_height", frame_height, 4095);
        chk("rst_geom_valid", geom_valid, 0);    chk("rst_overflow", overflow, 0);
    endtask

    // One input cycle; pix says whether the model treats it as a window pixel at column c, row = lines
    task automatic cyc(input bit v, input bit d, input bit pix, input int c);
        bit h, fs, e;
        h  = 1'($urandom_range(0, 1));
        fs = pix && !in_frame;
        e  = pix && (c == 0 || lines == 0 || (geom && (c == lw - 1 || lines == fh - 1)));
        if (pix) in_frame = 1;
        if (fs) fcnt++;
        @(negedge clk);
        hsync_dl = h; vsync_dl = v; de_dl = d;
        @(posedge clk);
        #1;
        chk("hsync_o", hsync_o, h); chk("vsync_o", vsync_o, v); chk("de_o", de_o, d);
        chk("border", border, pix && e);
        chk("win_valid", win_valid, pix && !e);
        chk("frame_start", frame_start, fs);
        if (pix) begin
            chk("col", col, c);
            chk("row", row, lines);
        end
        chk("overflow", overflow, ovf);
        chk("geom_valid", geom_valid, geom);
        chk("line_width", line_width, lw);
        chk("frame_height", frame_height, fh);
`ifdef SOBEL_WIN_STATS_EN
        chk("frame_cnt", frame_cnt, fcnt);
        chk("ovf_cnt", ovf_cnt, ocnt);
`endif
        if (win_valid) wv_cnt++;
    endtask

    task automatic vblank(input int vsl, input int gap, input bit d);
        if (in_frame) begin fh = lines; geom = 1; end
        if (ovf) ocnt++;
        ovf = 0; in_frame = 0; lines = 0; active = 1;
        cyc(1'b1, d, 1'b0, 0);
        for (int i = 1; i < vsl; i++) cyc(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < gap; i++) cyc(1'b0, 1'b0, 1'b0, 0);
    endtask

    // A line of w pixels then hb blank cycles; cut >= 0 raises vsync (with de still high) at that pixel
    task automatic line(input int w, input int hb, input int cut, input int vsl, input int gap);
        for (int c = 0; c < w; c++) begin
            if (c == cut) begin
                vblank(vsl, gap, 1'b1);
                return;
            end
            if (active && c >= W) ovf = 1;
            cyc(1'b0, 1'b1, active, c);
        end
        for (int i = 0; i < hb; i++) begin
            if (i == 0 && in_frame) begin lw = w; lines++; end
            cyc(1'b0, 1'b0, 1'b0, 0);
        end
    endtask

    initial begin
        int w, h, hb, vsl, gap;
        reset_model();
        repeat (2) @(posedge clk);
        #1 chk_reset();
        @(negedge clk);
        rst = 1'b1;

        vblank(2, 2, 1'b0);
        repeat (3) line(4, 2, -1, 0, 0);
        chk("geom_first_frame", geom_valid, 0);
        wv_cnt = 0;
        vblank(2, 2, 1'b0);
        chk("geom_second", geom_valid, 1);
        chk("lw_second", line_width, 4);
        chk("fh_second", frame_height, 3);
        repeat (3) line(4, 2, -1, 0, 0);
        chk("win_count_second", wv_cnt, 2);

        vblank(1, 1, 1'b0);
        line(9, 2, -1, 0, 0);
        chk("ovf_held", overflow, 1);
        line(4, 2, -1, 0, 0);
        line(4, 2, -1, 0, 0);
        vblank(1, 1, 1'b0);
        chk("ovf_cleared", overflow, 0);

        line(4, 2, -1, 0, 0);
        line(4, 2, 2, 2, 2);
        chk("abort_fh", frame_height, 1);
        repeat (3) line(4, 2, -1, 0, 0);
        vblank(2, 1, 1'b0);
        chk("after_abort_fh", frame_height, 3);

        repeat (6) begin
            w = 3 + $urandom_range(0, 6); h = 2 + $urandom_range(0, 2);
            hb = 1 + $urandom_range(0, 2); vsl = 1 + $urandom_range(0, 2); gap = 1 + $urandom_range(0, 2);
            repeat (h) line(w, hb, -1, 0, 0);
            vblank(vsl, gap, 1'b0);
        end

        line(5, 0, -1, 0, 0);
        #2 rst = 1'b0;
        #1 reset_model();
        chk_reset();
        @(negedge clk);
        rst = 1'b1;
        wv_cnt = 0;
        line(4, 2, -1, 0, 0);
        line(4, 2, -1, 0, 0);
        chk("idle_no_win", wv_cnt, 0);
        vblank(1, 1, 1'b0);
        chk("geom_after_reset", geom_valid, 0);
        repeat (2) line(3, 1, -1, 0, 0);
        vblank(1, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
